pkt_sink: RTL

//  Per-node packet receiver and checker: the consuming end of the traffic generator's valid/data/dest/pktsize

---
 rtl/pkt_sink_if.sv | 14 +
 rtl/pkt_sink.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pkt_sink_if.sv
// Traffic generator to packet sink handshake bundle: per-port valid/ready with data, dest and pktsize.
interface pkt_sink_if #(
   parameter int unsigned WIDTH = 512,
   parameter int unsigned N     = 16
);
   logic [N-1:0]            i_valid;
   logic [N-1:0]            o_ready;
   logic [N-1:0][WIDTH-1:0] i_data;
   logic [N-1:0][7:0]       i_dest;
   logic [N-1:0][15:0]      i_pktsize;

   modport master (output i_valid, output i_data, output i_dest, output i_pktsize, input o_ready);
   modport slave  (input i_valid, input i_data, input i_dest, input i_pktsize, output o_ready);
endinterface

// File: rtl/pkt_sink.sv
// Per-port packet receiver: serialisation timing, dest/size checking and saturating statistics.
// Optional PKT_SINK_SIZECHK_EN adds MIN_SIZE/MAX_SIZE range checking to err_size.
module pkt_sink #(
   parameter int unsigned WIDTH    = 512,
   parameter int unsigned N        = 16,
   parameter int unsigned MIN_SIZE = 512,
   parameter int unsigned MAX_SIZE = 640
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_clear,
   pkt_sink_if.slave           bus,
   output logic [N-1:0][31:0]  o_pkt_count,
   output logic [N-1:0][31:0]  o_byte_count,
   output logic [N-1:0]        o_err_dest,
   output logic [N-1:0]        o_err_size,
   output logic                o_err_any
);
   localparam int unsigned BEAT_BYTES = WIDTH / 8;
   localparam int unsigned CW         = 17;
   localparam logic [0:0]  IDLE       = 1'b0;
   localparam logic [0:0]  BUSY       = 1'b1;

   logic [N-1:0]          state_q, state_d;
   logic [N-1:0][CW-1:0]  busy_cnt_q, busy_cnt_d;
   logic [N-1:0]          ready_q, ready_d;
   logic [N-1:0][31:0]    pkt_cnt_q, pkt_cnt_d;
   logic [N-1:0][31:0]    byte_cnt_q, byte_cnt_d;
   logic [N-1:0]          err_dest_q, err_dest_d;
   logic [N-1:0]          err_size_q, err_size_d;
   logic                  err_any_q, err_any_d;

   logic [N-1:0]          accept_c;
   logic [N-1:0][CW-1:0]  beats_c;
   logic [N-1:0]          size_bad_c;
   logic                  data_unused_c;

   // Payload is consumed but not inspected.
   assign data_unused_c = ^bus.i_data;

   // Accept qualification, beat count and size legality per port
   always_comb begin
      accept_c   = '0;
      beats_c    = '0;
      size_bad_c = '0;
      for (int k = 0; k < int'(N); k++) begin
         accept_c[k] = bus.i_valid[k] & ready_q[k];
         if (bus.i_pktsize[k] == 16'd0) begin
            beats_c[k] = CW'(1);
         end else begin
            beats_c[k] = (CW'(bus.i_pktsize[k]) + CW'(BEAT_BYTES - 1)) / CW'(BEAT_BYTES);
         end
`ifdef PKT_SINK_SIZECHK_EN
         size_bad_c[k] = (bus.i_pktsize[k] == 16'd0) ||
                         (32'(bus.i_pktsize[k]) < MIN_SIZE) ||
                         (32'(bus.i_pktsize[k]) > MAX_SIZE);
`else
         size_bad_c[k] = (bus.i_pktsize[k] == 16'd0);
`endif
      end
   end

`ifndef PKT_SINK_SIZECHK_EN
   logic size_unused_c;
   assign size_unused_c = ^{32'(MIN_SIZE), 32'(MAX_SIZE)};
`endif

   // Per-port serialisation FSM; ready follows the next state so it is a flop output
   always_comb begin
      state_d    = state_q;
      busy_cnt_d = busy_cnt_q;
      ready_d    = '0;
      for (int k = 0; k < int'(N); k++) begin
         case (state_q[k])
            IDLE: begin
               if (accept_c[k] && (beats_c[k] > CW'(1))) begin
                  state_d[k]    = BUSY;
                  busy_cnt_d[k] = beats_c[k] - CW'(1);
               end
            end
            BUSY: begin
               if (busy_cnt_q[k] == CW'(1)) begin
                  state_d[k]    = IDLE;
                  busy_cnt_d[k] = '0;
               end else begin
                  busy_cnt_d[k] = busy_cnt_q[k] - CW'(1);
               end
            end
            default: begin
               state_d[k]    = IDLE;
               busy_cnt_d[k] = '0;
            end
         endcase
         ready_d[k] = (state_d[k] == IDLE);
      end
   end

   // Statistics and sticky flags; clear beats a coincident accept
   always_comb begin
      logic [32:0] pkt_sum;
      logic [32:0] byte_sum;
      pkt_cnt_d  = pkt_cnt_q;
      byte_cnt_d = byte_cnt_q;
      err_dest_d = err_dest_q;
      err_size_d = err_size_q;
      err_any_d  = (|err_dest_q) | (|err_size_q);
      pkt_sum    = '0;
      byte_sum   = '0;
      for (int k = 0; k < int'(N); k++) begin
         pkt_sum  = 33'(pkt_cnt_q[k]) + 33'd1;
         byte_sum = 33'(byte_cnt_q[k]) + 33'(bus.i_pktsize[k]);
         if (i_clear) begin
            pkt_cnt_d[k]  = '0;
            byte_cnt_d[k] = '0;
            err_dest_d[k] = 1'b0;
            err_size_d[k] = 1'b0;
         end else if (accept_c[k]) begin
            pkt_cnt_d[k]  = pkt_sum[32]  ? 32'hFFFF_FFFF : pkt_sum[31:0];
            byte_cnt_d[k] = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
            if (32'(bus.i_dest[k]) != 32'(k)) begin
               err_dest_d[k] = 1'b1;
            end
            if (size_bad_c[k]) begin
               err_size_d[k] = 1'b1;
            end
         end
      end
      if (i_clear) begin
         err_any_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= {N{IDLE}};
         busy_cnt_q <= '0;
         ready_q    <= '0;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
         err_dest_q <= '0;
         err_size_q <= '0;
         err_any_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_cnt_q <= busy_cnt_d;
         ready_q    <= ready_d;
         pkt_cnt_q  <= pkt_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         err_dest_q <= err_dest_d;
         err_size_q <= err_size_d;
         err_any_q  <= err_any_d;
      end
   end

   assign bus.o_ready   = ready_q;
   assign o_pkt_count   = pkt_cnt_q;
   assign o_byte_count  = byte_cnt_q;
   assign o_err_dest    = err_dest_q;
   assign o_err_size    = err_size_q;
   assign o_err_any     = err_any_q;
endmodule
